pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline around the execute stage: detects RAW hazards between ID sources and
//  EX/MEM destinations, stalls IF/ID and injects an EX bubble, flushes on EX-resolved branches, and freezes
//  the whole pipeline while the data memory is busy. Sits beside the stage registers; drives their freeze/flush.
// PARAMETERS
//  REG_ADDR_W   4      register-address width (`REG_ADDRESS_LEN)
//  FWD_EN       0      1: forwarding exists, stall only on load-use; 0: stall on any EX/MEM wb hazard
//  FLUSH_EXTRA  0      extra flush cycles after the branch cycle (0..3)
//  MEM_TIMEOUT  255    MEM_WAIT cycles before mem_timeout sets (1..65535)
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           synchronous, active-high reset
//  id_valid       in   1           ID holds a real instruction
//  id_src1        in   REG_ADDR_W  ID source Rn
//  id_src2        in   REG_ADDR_W  ID source Rm/Rd (store)
//  id_two_src     in   1           id_src2 is read
//  ex_dest        in   REG_ADDR_W  EX destination
//  ex_wb_en       in   1           EX writes back
//  ex_mem_r_en    in   1           EX is a load
//  mem_dest       in   REG_ADDR_W  MEM destination
//  mem_wb_en      in   1           MEM writes back
//  branch_taken   in   1           EX branch resolved taken
//  mem_req        in   1           MEM stage accesses memory this cycle
//  mem_ready      in   1           memory completes access this cycle
//  freeze_if      out  1           hold PC and IF/ID
//  freeze_id      out  1           hold ID decode (same as freeze_if)
//  bubble_ex      out  1           load NOP (all enables 0) into ID/EX
//  flush          out  1           clear IF/ID and ID/EX valid bits
//  freeze_all     out  1           hold every pipeline register
//  ctrl_state     out  2           FSM state (debug)
//  stall_cycles   out  16          saturating count of hazard-stall cycles
//  mem_timeout    out  1           sticky: MEM_WAIT exceeded MEM_TIMEOUT
// BEHAVIOUR
//  - Reset (sync): state=RUN, counters 0, mem_timeout 0; all outputs 0 in the reset cycle.
//  - States: RUN=0, MEM_WAIT=1, FLUSH=2. Outputs are combinational from state+inputs (0-cycle latency).
//  - hazard = id_valid & ((ex_wb_en & hit(ex_dest) & (!FWD_EN | ex_mem_r_en)) | (!FWD_EN & mem_wb_en & hit(mem_dest)));
//    hit(d) = (id_src1==d) | (id_two_src & id_src2==d).
//  - Priority per cycle: memory freeze > flush > hazard stall; only the winner's outputs assert.
//  - RUN: mem_req & !mem_ready -> freeze_all=1, next MEM_WAIT. Else branch_taken -> flush=1, next FLUSH if
//    FLUSH_EXTRA>0 else RUN. Else hazard -> freeze_if=freeze_id=bubble_ex=1, stay RUN. mem_req & mem_ready: no freeze.
//  - MEM_WAIT: freeze_all=1 until the cycle mem_ready=1 (freeze_all=0 that cycle), then RUN. Wait counter
//    increments per MEM_WAIT cycle; reaching MEM_TIMEOUT sets mem_timeout (sticky until rst); state keeps waiting.
//    branch_taken seen during freeze is ignored; it is held in EX and acted on after release.
//  - FLUSH: flush=1 for FLUSH_EXTRA cycles (down-counter), then RUN; hazards ignored; mem_req & !mem_ready
//    -> MEM_WAIT with remaining flush count kept, resumes FLUSH after release.
//  - stall_cycles +1 each cycle bubble_ex=1; saturates at 16'hFFFF.
//  - Reset mid-MEM_WAIT/FLUSH: immediate RUN next edge; no residual flush/freeze.
// STRUCTURE
//  - State encodings HZ_RUN/HZ_MEM_WAIT/HZ_FLUSH as `define in Defines.v beside existing widths.
//  - Sub-module hazard_detect_unit: combinational hazard equation above; FSM, counters in this module.
// TESTING
//  - id_src1=3, ex_dest=3, ex_wb_en=1, FWD_EN=0 -> freeze_if=bubble_ex=1 one cycle; stall_cycles=1.
//  - FWD_EN=1, same hit, ex_mem_r_en=0 -> no stall; ex_mem_r_en=1 -> stall.
//  - branch_taken=1 with hazard, FLUSH_EXTRA=2 -> flush=1 three cycles, bubble_ex=0 throughout.
//  - mem_req=1, mem_ready=0 for 4 cycles then 1 -> freeze_all=1 four cycles, 0 on ready cycle, RUN after.
//  - MEM_TIMEOUT=3, mem_ready held 0 -> mem_timeout=1 after 3rd wait cycle; stays 1 until rst.
//  - rst=1 in MEM_WAIT -> next cycle state=0, all outputs 0, stall_cycles=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard sequencer.
// Holds the FSM state encoding and counter widths.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hz_state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// RAW hazard detection between the ID sources and the EX/MEM destinations.
// With forwarding present only a load in EX can force a stall.
module hazard_detect_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter bit FWD_EN     = 1'b0
) (
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_src1,
    input  logic [REG_ADDR_W-1:0] i_id_src2,
    input  logic                  i_id_two_src,
    input  logic [REG_ADDR_W-1:0] i_ex_dest,
    input  logic                  i_ex_wb_en,
    input  logic                  i_ex_mem_r_en,
    input  logic [REG_ADDR_W-1:0] i_mem_dest,
    input  logic                  i_mem_wb_en,
    output logic                  o_hazard
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_ex_haz;
    logic w_mem_haz;

    assign w_ex_hit  = (i_id_src1 == i_ex_dest)
                     | (i_id_two_src & (i_id_src2 == i_ex_dest));
    assign w_mem_hit = (i_id_src1 == i_mem_dest)
                     | (i_id_two_src & (i_id_src2 == i_mem_dest));

    assign w_ex_haz  = i_ex_wb_en & w_ex_hit & (!FWD_EN | i_ex_mem_r_en);
    assign w_mem_haz = !FWD_EN & i_mem_wb_en & w_mem_hit;

    assign o_hazard  = i_id_valid & (w_ex_haz | w_mem_haz);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: hazard stall, branch flush and memory freeze.
// Outputs decode combinationally from the current state and inputs.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter bit FWD_EN      = 1'b0,
    parameter int FLUSH_EXTRA = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  freeze_if,
    output logic                  freeze_id,
    output logic                  bubble_ex,
    output logic                  flush,
    output logic                  freeze_all,
    output logic [1:0]            ctrl_state,
    output logic [15:0]           stall_cycles,
    output logic                  mem_timeout
);

    localparam logic [1:0]       FLUSH_INIT  = 2'(FLUSH_EXTRA);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT);

    hz_state_e        r_state;
    logic [1:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;

    logic             w_hazard;
    logic             w_mem_stall;
    logic             w_stall;
    logic             w_flush;
    logic             w_freeze_all;
    logic [CNT_W:0]   w_wait_inc;

    hazard_detect_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_hdu (
        .i_id_valid    (id_valid),
        .i_id_src1     (id_src1),
        .i_id_src2     (id_src2),
        .i_id_two_src  (id_two_src),
        .i_ex_dest     (ex_dest),
        .i_ex_wb_en    (ex_wb_en),
        .i_ex_mem_r_en (ex_mem_r_en),
        .i_mem_dest    (mem_dest),
        .i_mem_wb_en   (mem_wb_en),
        .o_hazard      (w_hazard)
    );

    assign w_mem_stall = mem_req & !mem_ready;
    assign w_wait_inc  = {1'b0, r_wait_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // Memory freeze beats flush beats hazard stall; only the winner asserts.
    always_comb begin
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        w_freeze_all = 1'b0;
        if (!rst) begin
            case (r_state)
                HZ_RUN: begin
                    if (w_mem_stall)
                        w_freeze_all = 1'b1;
                    else if (branch_taken)
                        w_flush = 1'b1;
                    else if (w_hazard)
                        w_stall = 1'b1;
                end
                HZ_MEM_WAIT: w_freeze_all = !mem_ready;
                HZ_FLUSH: begin
                    if (w_mem_stall)
                        w_freeze_all = 1'b1;
                    else
                        w_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HZ_RUN;
            r_flush_cnt <= 2'd0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_stall && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            case (r_state)
                HZ_RUN: begin
                    r_wait_cnt <= '0;
                    if (w_mem_stall) begin
                        r_state <= HZ_MEM_WAIT;
                    end else if (branch_taken && FLUSH_EXTRA > 0) begin
                        r_state     <= HZ_FLUSH;
                        r_flush_cnt <= FLUSH_INIT;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (mem_ready) begin
                        // A flush interrupted by memory resumes with its count.
                        if (r_flush_cnt != 2'd0)
                            r_state <= HZ_FLUSH;
                        else
                            r_state <= HZ_RUN;
                    end else begin
                        if (r_wait_cnt != CNT_MAX)
                            r_wait_cnt <= w_wait_inc[CNT_W-1:0];
                        if (w_wait_inc >= {1'b0, TIMEOUT_LIM})
                            r_timeout <= 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    r_wait_cnt <= '0;
                    if (w_mem_stall) begin
                        r_state <= HZ_MEM_WAIT;
                    end else begin
                        if (r_flush_cnt != 2'd0)
                            r_flush_cnt <= r_flush_cnt - 2'd1;
                        if (r_flush_cnt <= 2'd1)
                            r_state <= HZ_RUN;
                    end
                end
                default: r_state <= HZ_RUN;
            endcase
        end
    end

    assign freeze_if    = w_stall;
    assign freeze_id    = w_stall;
    assign bubble_ex    = w_stall;
    assign flush        = w_flush;
    assign freeze_all   = w_freeze_all;
    assign ctrl_state   = rst ? 2'd0 : r_state;
    assign stall_cycles = rst ? 16'd0 : r_stall_cnt;
    assign mem_timeout  = rst ? 1'b0 : r_timeout;

endmodule
